muldiv_unit: RTL

//  HI/LO multiply-divide unit for the MIPS 5-stage pipelined CPU, sitting beside the ALU in EXE.
//  - Executes MULT/MULTU/DIV/DIVU as multi-cycle operations, and MTHI/MTLO/MFHI/MFLO in one cycle.
//  - Owns the HI/LO registers.
//  - Generalises the decoder's single-cycle ALU path with parametrised width, multiply latency and divide radix.
//  - Produces a stall towards the pipeline while an operation is in flight.

---
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - pipeline-side bus of the HI/LO multiply/divide unit
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  op_valid;
  logic [3:0]            op;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  cancel;
  logic                  stall;
  logic                  busy;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  div_zero;
  logic                  unrecognized;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output en, op_valid, op, src_a, src_b, cancel,
    input  stall, busy, rd_data, div_zero, unrecognized, hi, lo
  );

  modport slave (
    input  en, op_valid, op, src_a, src_b, cancel,
    output stall, busy, rd_data, div_zero, unrecognized, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO multiply/divide unit with multi-cycle MULT/DIV and pipeline stall
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int MUL_LATENCY   = 3,
  parameter int DIV_STEP_BITS = 1
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int W          = DATA_WIDTH;
  localparam int DIV_CYCLES = W / DIV_STEP_BITS;
  localparam int CNT_MAX    = (MUL_LATENCY > DIV_CYCLES) ? MUL_LATENCY : DIV_CYCLES;
  localparam int CW         = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   hi_q, lo_q;
  logic [W-1:0]   a_q, b_q, rem_q;
  logic           mul_signed, neg_quo, neg_rem, div_zero_q;
  logic           op_known, busy, stall, accept, div_signed;
  logic [W-1:0]   mag_a, mag_b;
  logic [2*W-1:0] ext_a, ext_b, product;
  logic [W-1:0]   rem_nx, quo_nx;
  logic [W:0]     shifted;

  assign op_known   = (bus.op != 4'd0) && (bus.op <= OP_MFLO);
  assign div_signed = (bus.op == OP_DIV);
  assign mag_a      = (div_signed && bus.src_a[W-1]) ? -bus.src_a : bus.src_a;
  assign mag_b      = (div_signed && bus.src_b[W-1]) ? -bus.src_b : bus.src_b;

  // Sign-extending to 2W and keeping the low 2W bits gives both MULT and MULTU.
  assign ext_a   = {{W{mul_signed & a_q[W-1]}}, a_q};
  assign ext_b   = {{W{mul_signed & b_q[W-1]}}, b_q};
  assign product = ext_a * ext_b;

  // Restoring divide: a_q shifts out dividend bits and collects quotient bits.
  always_comb begin
    rem_nx  = rem_q;
    quo_nx  = a_q;
    shifted = '0;
    for (int i = 0; i < DIV_STEP_BITS; i++) begin
      shifted = {rem_nx, quo_nx[W-1]};
      quo_nx  = {quo_nx[W-2:0], 1'b0};
      if (shifted >= {1'b0, b_q}) begin
        rem_nx    = W'(shifted - {1'b0, b_q});
        quo_nx[0] = 1'b1;
      end else begin
        rem_nx = shifted[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    busy    = (state != S_IDLE);
    stall   = bus.op_valid & busy & op_known;
    accept  = (state == S_IDLE) & bus.en & bus.op_valid & ~stall & ~bus.cancel;
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bus.op == OP_MULT || bus.op == OP_MULTU)
            state_n = S_MUL;
          else if ((bus.op == OP_DIV || bus.op == OP_DIVU) && bus.src_b != '0)
            state_n = S_DIV;
        end
      end
      S_MUL:   if (bus.cancel || cnt == '0) state_n = S_IDLE;
      S_DIV:   if (bus.cancel) state_n = S_IDLE; else if (cnt == '0) state_n = S_FIX;
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      cnt        <= '0;
      mul_signed <= 1'b0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      div_zero_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                a_q        <= bus.src_a;
                b_q        <= bus.src_b;
                mul_signed <= (bus.op == OP_MULT);
                cnt        <= CW'(MUL_LATENCY - 1);
              end
              OP_DIV, OP_DIVU: begin
                if (bus.src_b == '0) begin
                  hi_q       <= bus.src_a;
                  lo_q       <= '1;
                  div_zero_q <= 1'b1;
                end else begin
                  a_q     <= mag_a;
                  b_q     <= mag_b;
                  rem_q   <= '0;
                  neg_quo <= div_signed & (bus.src_a[W-1] ^ bus.src_b[W-1]);
                  neg_rem <= div_signed & bus.src_a[W-1];
                  cnt     <= CW'(DIV_CYCLES - 1);
                end
              end
              OP_MTHI: hi_q <= bus.src_a;
              OP_MTLO: lo_q <= bus.src_a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (!bus.cancel) begin
            if (cnt == '0) {hi_q, lo_q} <= product;
            else           cnt <= cnt - CW'(1);
          end
        end
        S_DIV: begin
          if (!bus.cancel) begin
            rem_q <= rem_nx;
            a_q   <= quo_nx;
            if (cnt != '0) cnt <= cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (!bus.cancel) begin
            hi_q <= neg_rem ? -rem_q : rem_q;
            lo_q <= neg_quo ? -a_q : a_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = busy;
  assign bus.stall        = stall;
  assign bus.div_zero     = div_zero_q;
  assign bus.unrecognized = bus.op_valid & (bus.op > OP_MFLO);
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.rd_data      = (bus.op == OP_MFHI) ? hi_q :
                            (bus.op == OP_MFLO) ? lo_q : '0;
endmodule
